dac_sample_tx: RTL and testbench
================================

# dac_sample_tx

Output-side serializer for the effects pedal's audio path. It accepts processed 8-bit samples on a one-cycle ready strobe and buffers them in a small FIFO. It then transmits each sample as a 16-bit frame to a serial 8-bit DAC over a three-wire SYNC/SCLK/DIN link, mirroring the strobed ADC capture at the front of the chain. It sits after the equalizer/effect datapath and drives the DAC pins directly.

## Interface

- DEPTH, 8, FIFO depth in samples; power of two, ≥2
- CLKDIV, 4, clk cycles per SCLK half-period; ≥2
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- samplein  input  8  sample to transmit; valid when RDYsample=1
- RDYsample  input  1  one-cycle write strobe for samplein
- dac_sync_n  output  1  frame enable to DAC, active low
- dac_sclk  output  1  serial clock; idles high; DAC captures DIN on falling edge
- dac_din  output  1  serial data, MSB first
- busy  output  1  high while a frame or inter-frame gap is in progress
- fifo_count  output  $clog2(DEPTH)+1  samples currently held in FIFO
- overflow  output  1  one-cycle pulse when a write is dropped

## Operation

- Frame format, 16 bits, MSB first: {4'b0000, sample[7:0], 4'b0000}. Upper nibble is control (normal mode). Lower nibble is don't-care, driven 0.
- FIFO: circular buffer of DEPTH×8 with read/write pointers and fifo_count. Write when RDYsample=1 and not full. Pop only from FSM IDLE.
- Write while full: sample dropped, FIFO unchanged, overflow=1 for that cycle. Exception: a write in the same cycle as a pop is accepted, with count unchanged and no overflow.
- A write to an empty FIFO cannot be popped in the same cycle. It is popped no earlier than the next cycle.
- FSM states:
  - IDLE: sync_n=1, sclk=1, din=0, busy=0. If fifo_count≠0, pop into the 16-bit shift register and go to SHIFT_HI with bit counter=15.
  - SHIFT_HI: sync_n=0, sclk=1, din=shift[15]. Hold CLKDIV cycles, then go to SHIFT_LO. The falling edge is the DAC capture point.
  - SHIFT_LO: sclk=0, din unchanged. Hold CLKDIV cycles. If bit counter=0, go to GAP. Otherwise shift left by 1, decrement counter, and go to SHIFT_HI.
  - GAP: sync_n=1, sclk=1, din=0, busy=1. Hold CLKDIV cycles, then go to IDLE.
- A single half-period counter is shared by all timed states and reloaded on every state change.
- din changes only while sclk=1 (on entry to SHIFT_HI), never coincident with a falling edge.
- All outputs are registered; no combinational path from inputs to pins.

## Timing

- Reset values: dac_sync_n=1, dac_sclk=1, dac_din=0, busy=0, fifo_count=0, overflow=0. FIFO pointers are cleared and the FSM goes to IDLE.
- Reset mid-frame aborts the frame. Pins show idle values in the cycle after the reset edge. Buffered samples are discarded.
- RDYsample sampled at edge 0 with FIFO empty and FSM idle:
  - fifo_count=1 after edge 0.
  - Pop at edge 1; fifo_count=0 and dac_sync_n=0 after edge 1.
- Frame duration: 32·CLKDIV cycles with dac_sync_n low (16 falling SCLK edges), plus CLKDIV GAP cycles. This is 132 cycles at CLKDIV=4.
- Back-to-back: the next pop occurs at the edge leaving IDLE one cycle after GAP ends. Frame period is 33·CLKDIV+1 cycles (133 at CLKDIV=4).
- dac_sync_n and dac_sclk rise together at the end of the final SHIFT_LO.
- busy=1 from the pop edge until the FSM returns to IDLE.

## Test plan

- Single sample 0xA5, CLKDIV=4: dac_sync_n low for exactly 128 cycles with 16 falling SCLK edges. DIN captured at falls = 0000_1010_0101_0000. busy returns to 0 after 132 cycles.
- Three writes 0x01, 0x80, 0xFF on consecutive cycles: three frames in order. Each pair of frames is separated by ≥4 cycles of dac_sync_n=1. overflow stays 0 and fifo_count peaks at 2.
- Ten writes 0x00..0x09 on consecutive cycles from idle: overflow pulses only on the 0x09 write and fifo_count reaches 8. Exactly nine frames are sent, carrying 0x00..0x08.
- FIFO full while busy, with a write in the exact cycle of the next pop: write accepted, no overflow pulse, fifo_count stays 8. The sample is transmitted last.
- Reset asserted 40 cycles into a frame with 3 samples queued: next cycle shows dac_sync_n=1, dac_sclk=1, dac_din=0, fifo_count=0, busy=0. No further frames follow.
- DIN stability check across all frames: dac_din never toggles in a cycle where dac_sclk falls, and dac_sclk never toggles while dac_sync_n=1.

Source files
------------

// File: rtl/dac_sample_tx.sv
// Output-side DAC serializer: buffers strobed 8-bit samples in a FIFO and
// sends each one as a 16-bit SYNC/SCLK/DIN frame, MSB first.
module dac_sample_tx #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CLKDIV = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 samplein,
    input  logic                       RDYsample,
    output logic                       dac_sync_n,
    output logic                       dac_sclk,
    output logic                       dac_din,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = $clog2(CLKDIV);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SHIFT_HI = 2'd1;
    localparam logic [1:0] S_SHIFT_LO = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    state, state_d;
    logic [HW-1:0] hcnt, hcnt_d;
    logic [3:0]    bcnt, bcnt_d;
    logic [15:0]   shift, shift_d;
    logic          sync_n_d, sclk_d, din_d, busy_d;
    logic          full, pop, wr_ok;

    assign full  = (fifo_count == CW'(DEPTH));
    assign pop   = (state == S_IDLE) && (fifo_count != '0);
    // A write into a full FIFO still fits when the same edge frees a slot.
    assign wr_ok = RDYsample && (!full || pop);

    // Sample storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= samplein;
        end
    end

    // FIFO pointers, occupancy and overflow strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!wr_ok && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
            overflow <= RDYsample && full && !pop;
        end
    end

    // FSM state, timing counters and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hcnt       <= '0;
            bcnt       <= '0;
            shift      <= '0;
            dac_sync_n <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            hcnt       <= hcnt_d;
            bcnt       <= bcnt_d;
            shift      <= shift_d;
            dac_sync_n <= sync_n_d;
            dac_sclk   <= sclk_d;
            dac_din    <= din_d;
            busy       <= busy_d;
        end
    end

    // Next state; the half-period counter reloads on every state change.
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        bcnt_d  = bcnt;
        shift_d = shift;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SHIFT_HI;
                    hcnt_d  = HW'(CLKDIV - 1);
                    bcnt_d  = 4'd15;
                    shift_d = {4'b0000, mem[rd_ptr], 4'b0000};
                end
            end
            S_SHIFT_HI: begin
                if (hcnt == '0) begin
                    state_d = S_SHIFT_LO;
                    hcnt_d  = HW'(CLKDIV - 1);
                end else begin
                    hcnt_d = hcnt - HW'(1);
                end
            end
            S_SHIFT_LO: begin
                if (hcnt == '0) begin
                    hcnt_d = HW'(CLKDIV - 1);
                    if (bcnt == 4'd0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SHIFT_HI;
                        bcnt_d  = bcnt - 4'd1;
                        shift_d = {shift[14:0], 1'b0};
                    end
                end else begin
                    hcnt_d = hcnt - HW'(1);
                end
            end
            default: begin
                if (hcnt == '0) begin
                    state_d = S_IDLE;
                    hcnt_d  = HW'(CLKDIV - 1);
                end else begin
                    hcnt_d = hcnt - HW'(1);
                end
            end
        endcase
    end

    // Pin values follow the next state so every pin comes straight from a flop.
    always_comb begin
        sync_n_d = 1'b1;
        sclk_d   = 1'b1;
        din_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);
        if (state_d == S_SHIFT_HI || state_d == S_SHIFT_LO) begin
            sync_n_d = 1'b0;
            din_d    = shift_d[15];
        end
        if (state_d == S_SHIFT_LO) begin
            sclk_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_tx.sv
// Directed bench for dac_sample_tx: frame content, timing, FIFO limits and reset abort.
module tb_dac_sample_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] samplein = 8'h00;
    logic       RDYsample = 1'b0;
    logic       dac_sync_n, dac_sclk, dac_din, busy, overflow;
    logic [3:0] fifo_count;

    dac_sample_tx #(.DEPTH(8), .CLKDIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .samplein   (samplein),
        .RDYsample  (RDYsample),
        .dac_sync_n (dac_sync_n),
        .dac_sclk   (dac_sclk),
        .dac_din    (dac_din),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          falls;
        int          low;
        int          gap;
    } frame_t;

    frame_t     frames[$];
    frame_t     cur;
    int         viol = 0;
    int         hi_cnt = 0;
    logic       p_sync = 1'b1, p_sclk = 1'b1, p_din = 1'b0;
    logic [7:0] last_wr = 8'h00;

    int errors = 0;
    int checks = 0;
    int peak = 0;
    int ovf_n = 0;
    int ovf_val = 0;
    int nf = 0;
    int n = 0;
    int snap = 0;

    // Remember the sample value the DUT saw on the most recent write edge.
    always @(posedge clk) begin
        if (RDYsample) last_wr = samplein;
    end

    // Pin monitor: rebuilds frames from falling SCLK edges and flags glitches.
    always @(negedge clk) begin
        if (dac_sync_n === 1'b0) begin
            if (p_sync === 1'b1) begin
                cur = '{data: 16'h0000, falls: 0, low: 0, gap: hi_cnt};
            end
            cur.low++;
            if (p_sclk === 1'b1 && dac_sclk === 1'b0) begin
                cur.data = {cur.data[14:0], dac_din};
                cur.falls++;
                if (dac_din !== p_din) viol++;
            end
        end else begin
            if (p_sync === 1'b0) begin
                frames.push_back(cur);
                hi_cnt = 0;
            end
            hi_cnt++;
            if (p_sync === 1'b1 && dac_sclk !== p_sclk) viol++;
        end
        p_sync = dac_sync_n;
        p_sclk = dac_sclk;
        p_din  = dac_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (overflow === 1'b1) begin
            ovf_n++;
            ovf_val = int'(last_wr);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        samplein  = v;
        RDYsample = 1'b1;
        step();
        RDYsample = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while (!(busy === 1'b0 && fifo_count === 4'd0) && c < maxc) begin
            step();
            c++;
        end
        chk("idle_timeout", 32'(c < maxc), 32'd1);
    endtask

    function automatic logic [15:0] fr_data(input int i);
        if (i < frames.size()) return frames[i].data;
        return 16'hxxxx;
    endfunction

    function automatic int fr_gap(input int i);
        if (i < frames.size()) return frames[i].gap;
        return -1;
    endfunction

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_sync_n", 32'(dac_sync_n), 32'd1);
        chk("rst_sclk", 32'(dac_sclk), 32'd1);
        chk("rst_din", 32'(dac_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Single sample 0xA5: latency, frame length and content
        wr(8'hA5);
        chk("t1_count_after_wr", 32'(fifo_count), 32'd1);
        chk("t1_sync_after_wr", 32'(dac_sync_n), 32'd1);
        step();
        chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
        chk("t1_sync_after_pop", 32'(dac_sync_n), 32'd0);
        chk("t1_busy_after_pop", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        chk("t1_busy_cycles", 32'(n), 32'd132);
        chk("t1_nframes", 32'(frames.size()), 32'd1);
        chk("t1_data", 32'(fr_data(0)), 32'h0A50);
        if (frames.size() > 0) begin
            chk("t1_falls", 32'(frames[0].falls), 32'd16);
            chk("t1_low_cycles", 32'(frames[0].low), 32'd128);
        end
        nf = 1;

        // Three consecutive writes
        peak = 0; ovf_n = 0;
        wr(8'h01); wr(8'h80); wr(8'hFF);
        wait_idle(1000);
        chk("t2_nframes", 32'(frames.size()), 32'(nf + 3));
        chk("t2_f0", 32'(fr_data(nf)), 32'h0010);
        chk("t2_f1", 32'(fr_data(nf + 1)), 32'h0800);
        chk("t2_f2", 32'(fr_data(nf + 2)), 32'h0FF0);
        chk("t2_gap1", 32'(fr_gap(nf + 1)), 32'd5);
        chk("t2_gap2", 32'(fr_gap(nf + 2)), 32'd5);
        chk("t2_ovf", 32'(ovf_n), 32'd0);
        chk("t2_peak", 32'(peak), 32'd2);
        nf += 3;

        // Ten writes: the tenth overflows
        peak = 0; ovf_n = 0; ovf_val = -1;
        for (int i = 0; i < 10; i++) wr(8'(i));
        wait_idle(2000);
        chk("t3_ovf_pulses", 32'(ovf_n), 32'd1);
        chk("t3_ovf_value", 32'(ovf_val), 32'h09);
        chk("t3_peak", 32'(peak), 32'd8);
        chk("t3_nframes", 32'(frames.size()), 32'(nf + 9));
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t3_f%0d", i), 32'(fr_data(nf + i)), 32'({4'h0, 8'(i), 4'h0}));
        end
        nf += 9;

        // Full FIFO, write lands on the pop edge
        peak = 0; ovf_n = 0;
        for (int i = 0; i < 9; i++) wr(8'h20 + 8'(i));
        chk("t4_full", 32'(fifo_count), 32'd8);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        chk("t4_reach_idle", 32'(n < 300), 32'd1);
        chk("t4_count_at_idle", 32'(fifo_count), 32'd8);
        wr(8'h29);
        chk("t4_count_after_pop_wr", 32'(fifo_count), 32'd8);
        chk("t4_no_ovf_pulse", 32'(overflow), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_idle(3000);
        chk("t4_ovf", 32'(ovf_n), 32'd0);
        chk("t4_nframes", 32'(frames.size()), 32'(nf + 10));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_f%0d", i), 32'(fr_data(nf + i)), 32'({4'h0, 8'h20 + 8'(i), 4'h0}));
        end
        nf += 10;

        // Reset 40 cycles into a frame with three samples queued
        wr(8'h30); wr(8'h31); wr(8'h32); wr(8'h33);
        chk("t5_queued", 32'(fifo_count), 32'd3);
        repeat (37) step();
        chk("t5_mid_frame", 32'(dac_sync_n), 32'd0);
        reset = 1'b1;
        step();
        chk("t5_sync_n", 32'(dac_sync_n), 32'd1);
        chk("t5_sclk", 32'(dac_sclk), 32'd1);
        chk("t5_din", 32'(dac_din), 32'd0);
        chk("t5_count", 32'(fifo_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        snap = frames.size();
        repeat (400) step();
        chk("t5_no_more_frames", 32'(frames.size()), 32'(snap));
        chk("t5_still_idle", 32'(busy), 32'd0);

        chk("pin_stability", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
